// File: rtl/instr_fetch_buffer_pkg.sv
// fetch_pkg: shared constants and the queued entry type for the instruction fetch buffer
package fetch_pkg;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/instr_fetch_buffer_if.sv
// instr_fetch_buffer_if: request/response handshake between fetch (master) and instruction memory (slave)
interface instr_fetch_buffer_if;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    modport master (output imem_req_valid, imem_req_addr, input imem_req_ready, imem_rsp_valid, imem_rsp_data);
    modport slave (input imem_req_valid, imem_req_addr, output imem_req_ready, imem_rsp_valid, imem_rsp_data);
endinterface

// File: rtl/instr_fetch_buffer_fifo.sv
// fetch_fifo: synchronous FIFO of fetch entries with flush; push and pop may coincide even when full
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  logic                         i_flush,
    input  fetch_entry_t                 i_data,
    output fetch_entry_t                 o_head,
    output logic [$clog2(DEPTH+1)-1:0]   o_count,
    output logic                         o_full,
    output logic                         o_empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    fetch_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_rd_ptr;
    logic [AW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;
    // pointer and occupancy bookkeeping; a flush discards everything including a same-cycle push
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end
    // storage write; entries need no reset because occupancy gates their visibility
    always_ff @(posedge clk) begin
        if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end
endmodule

// File: rtl/instr_fetch_buffer.sv
// instr_fetch_buffer: sequential PC fetch with credit-limited imem requests and redirect flush (optional FETCH_BYPASS_EN)
module instr_fetch_buffer
    import fetch_pkg::*;
#(
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2,
    parameter logic [31:0] RESET_PC        = RESET_PC_DEFAULT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         PCSrcE,
    input  logic [31:0]                  PCTargetE,
    input  logic                         StallD,
    instr_fetch_buffer_if.master         imem,
    output logic [31:0]                  InstrF,
    output logic [31:0]                  PCF,
    output logic [31:0]                  PCPlus4F,
    output logic                         instr_valid
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_rsp_pc;
    logic [OW-1:0] r_outstanding;
    logic [OW-1:0] r_drop_cnt;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    fetch_entry_t  w_head;
    fetch_entry_t  w_entry;
    fetch_entry_t  w_out;
    logic [31:0]   w_credit;
    logic          w_accept;
    logic          w_rsp;
    logic          w_drop;
    logic          w_push_cand;
    logic          w_push;
    logic          w_pop_ok;
    logic          w_fifo_pop;
    logic          w_valid;
    // a response with nothing outstanding is a leftover from before reset and is ignored
    assign w_rsp       = imem.imem_rsp_valid && r_outstanding != '0;
    assign w_drop      = PCSrcE || r_drop_cnt != '0;
    assign w_push_cand = w_rsp && !w_drop;
    assign w_credit    = PCSrcE ? 32'd0 : 32'(w_count) + 32'(r_outstanding) - 32'(r_drop_cnt);
    assign imem.imem_req_valid = !rst && w_credit < 32'(DEPTH) && 32'(r_outstanding) < 32'(MAX_OUTSTANDING);
    assign imem.imem_req_addr  = PCSrcE ? PCTargetE : r_fetch_pc;
    assign w_accept    = imem.imem_req_valid && imem.imem_req_ready;
    assign w_pop_ok    = !StallD && !PCSrcE;
    assign w_fifo_pop  = !w_empty && w_pop_ok;
    assign w_entry     = '{pc: r_rsp_pc, instr: imem.imem_rsp_data};
`ifdef FETCH_BYPASS_EN
    logic w_byp;
    assign w_byp   = w_empty && w_push_cand;
    assign w_push  = w_push_cand && !(w_byp && w_pop_ok);
    assign w_out   = w_byp ? w_entry : w_head;
    assign w_valid = !w_empty || w_byp;
`else
    assign w_push  = w_push_cand;
    assign w_out   = w_head;
    assign w_valid = !w_empty;
`endif
    assign instr_valid = w_valid;
    assign InstrF      = w_valid ? w_out.instr : NOP_INSTR;
    assign PCF         = w_valid ? w_out.pc : 32'd0;
    assign PCPlus4F    = w_valid ? w_out.pc + 32'd4 : 32'd0;
    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_fifo_pop),
        .i_flush (PCSrcE),
        .i_data  (w_entry),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );
    // fetch PC, response PC tag, in-flight and to-be-dropped counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
        end else begin
            r_fetch_pc    <= w_accept ? imem.imem_req_addr + 32'd4 : PCSrcE ? PCTargetE : r_fetch_pc;
            r_rsp_pc      <= PCSrcE ? PCTargetE : w_push_cand ? r_rsp_pc + 32'd4 : r_rsp_pc;
            r_outstanding <= r_outstanding + OW'(w_accept) - OW'(w_rsp);
            r_drop_cnt    <= PCSrcE ? r_outstanding - OW'(w_rsp) : (w_rsp && r_drop_cnt != '0) ? r_drop_cnt - 1'b1 : r_drop_cnt;
        end
    end
    // the issue credit must make overflow impossible
    always_ff @(posedge clk) begin
        if (!rst) assert (!(w_push && w_full && !w_fifo_pop));
    end
endmodule

// File: tb/tb_instr_fetch_buffer.sv
// tb_instr_fetch_buffer: directed scoreboard bench with a variable-latency in-order memory model
module tb_instr_fetch_buffer;
    import fetch_pkg::*;
`ifdef FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCSrcE = 1'b0;
    logic        StallD = 1'b0;
    logic [31:0] PCTargetE = 32'd0;
    logic [31:0] InstrF;
    logic [31:0] PCF;
    logic [31:0] PCPlus4F;
    logic        instr_valid;
    int          checks = 0;
    int          errors = 0;
    int          n_pop = 0;
    int          cyc = 0;
    int          lat = 1;
    int          last_pop_cyc = 0;
    logic [31:0] exp_q [$];
    req_t        mem_q [$];

    instr_fetch_buffer_if imem();

    instr_fetch_buffer #(.DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .StallD      (StallD),
        .imem        (imem),
        .InstrF      (InstrF),
        .PCF         (PCF),
        .PCPlus4F    (PCPlus4F),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'hCAFE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] a, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(a + 32'(4 * i));
    endtask

    task automatic wait_pops(input int target);
        int b;
        b = 0;
        while (n_pop < target && b < 100) begin
            tick();
            b++;
        end
        checks++;
        if (n_pop < target) begin
            errors++;
            $display("FAIL pop_timeout: got %0d pops expected %0d", n_pop, target);
        end
        StallD = 1'b1;
    endtask

    task automatic stall_fill();
        StallD = 1'b1;
        imem.imem_req_ready = 1'b1;
        repeat (12) tick();
    endtask

    // memory model: records accepts at negedge, returns words in order after lat cycles
    initial begin
        int due;
        imem.imem_rsp_valid = 1'b0;
        imem.imem_rsp_data  = 32'd0;
        forever begin
            @(negedge clk);
            if (rst) mem_q.delete();
            else if (imem.imem_req_valid && imem.imem_req_ready) begin
                due = cyc + lat;
                if (mem_q.size() > 0 && mem_q[$].due >= due) due = mem_q[$].due + 1;
                mem_q.push_back('{imem.imem_req_addr, due});
            end
            @(posedge clk);
            #1;
            cyc++;
            if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
                imem.imem_rsp_valid = 1'b1;
                imem.imem_rsp_data  = word_of(mem_q[0].addr);
                void'(mem_q.pop_front());
            end else begin
                imem.imem_rsp_valid = 1'b0;
                imem.imem_rsp_data  = 32'd0;
            end
        end
    end

    // monitor: every consumed instruction is compared with the next expected PC
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && instr_valid && !StallD && !PCSrcE) begin
                n_pop++;
                last_pop_cyc = cyc;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL pop_unexpected: got pc %h expected none", PCF);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_pc", PCF, e);
                    check("pop_instr", InstrF, word_of(e));
                    check("pop_pc4", PCPlus4F, e + 32'd4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int p0;
        imem.imem_req_ready = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_instr", InstrF, NOP_INSTR);
        check("rst_pc", PCF, 32'd0);
        check("rst_pc4", PCPlus4F, 32'd0);
        check("rst_req_valid", 32'(imem.imem_req_valid), 32'd0);
        push_exp(32'h0, 8);
        tick();
        rst = 1'b0;
        @(negedge clk);
        base = cyc;
        check("c0_valid", 32'(instr_valid), 32'd0);
        check("c0_req", {31'd0, imem.imem_req_valid}, 32'd1);
        check("c0_addr", imem.imem_req_addr, 32'h0);
        tick();
        @(negedge clk);
        check("c1_valid", 32'(instr_valid), 32'd0);
        tick();
        @(negedge clk);
        check("c2_valid", 32'(instr_valid), 32'd1);
        check("c2_pc", PCF, 32'h0);
        tick();
        wait_pops(8);
        check("throughput", 32'(last_pop_cyc - base), 32'd9);

        stall_fill();
        PCSrcE = 1'b1;
        PCTargetE = 32'h800;
        tick();
        PCSrcE = 1'b0;
        repeat (10) tick();
        @(negedge clk);
        check("full_req_valid", 32'(imem.imem_req_valid), 32'd0);
        check("full_head_pc", PCF, 32'h800);
        tick();
        imem.imem_req_ready = 1'b0;
        push_exp(32'h800, 4);
        p0 = n_pop;
        StallD = 1'b0;
        repeat (7) tick();
        @(negedge clk);
        check("full_count", 32'(n_pop - p0), 32'd4);
        check("full_drained", 32'(instr_valid), 32'd0);
        tick();
        StallD = 1'b1;
        imem.imem_req_ready = 1'b1;

        stall_fill();
        lat = 3;
        PCSrcE = 1'b1;
        PCTargetE = 32'h200;
        tick();
        PCSrcE = 1'b0;
        @(negedge clk);
        check("flush_empty", 32'(instr_valid), 32'd0);
        tick();
        PCSrcE = 1'b1;
        PCTargetE = 32'h100;
        @(negedge clk);
        check("max_outstanding", 32'(imem.imem_req_valid), 32'd0);
        tick();
        PCSrcE = 1'b0;
        push_exp(32'h100, 6);
        StallD = 1'b0;
        wait_pops(n_pop + 6);

        stall_fill();
        lat = 2;
        PCSrcE = 1'b1;
        PCTargetE = 32'h300;
        tick();
        PCSrcE = 1'b0;
        tick();
        PCSrcE = 1'b1;
        PCTargetE = 32'h400;
        tick();
        PCSrcE = 1'b0;
        @(negedge clk);
        check("rsp_redirect_drop", 32'(instr_valid), 32'd0);
        tick();
        push_exp(32'h400, 4);
        StallD = 1'b0;
        wait_pops(n_pop + 4);

        stall_fill();
        lat = 1;
        imem.imem_req_ready = 1'b0;
        PCSrcE = 1'b1;
        PCTargetE = 32'h600;
        @(negedge clk);
        check("wait_addr0", imem.imem_req_addr, 32'h600);
        tick();
        PCSrcE = 1'b0;
        @(negedge clk);
        check("wait_addr1", imem.imem_req_addr, 32'h600);
        tick();
        PCSrcE = 1'b1;
        PCTargetE = 32'h500;
        @(negedge clk);
        check("wait_redirect_addr", imem.imem_req_addr, 32'h500);
        tick();
        PCSrcE = 1'b0;
        @(negedge clk);
        check("wait_held_addr", imem.imem_req_addr, 32'h500);
        tick();
        tick();
        imem.imem_req_ready = 1'b1;
        @(negedge clk);
        check("wait_accept_addr", imem.imem_req_addr, 32'h500);
        push_exp(32'h500, 6);
        tick();
        StallD = 1'b0;
        wait_pops(n_pop + 6);

        stall_fill();
        lat = 1;
        push_exp(32'h40, 6);
        p0 = n_pop;
        PCSrcE = 1'b1;
        PCTargetE = 32'h40;
        StallD = 1'b0;
        tick();
        PCSrcE = 1'b0;
        @(negedge clk);
        check("byp_valid", 32'(instr_valid), 32'(BYP));
        check("byp_pc", PCF, BYP ? 32'h40 : 32'h0);
        tick();
        @(negedge clk);
        check("byp_next_pc", PCF, BYP ? 32'h44 : 32'h40);
        tick();
        wait_pops(p0 + 6);

        stall_fill();
        push_exp(32'hFFFF_FFF8, 4);
        p0 = n_pop;
        PCSrcE = 1'b1;
        PCTargetE = 32'hFFFF_FFF8;
        StallD = 1'b0;
        tick();
        PCSrcE = 1'b0;
        wait_pops(p0 + 4);

        repeat (3) tick();
        check("exp_left", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_buffer.md
Name: instr_fetch_buffer

Overview:
Fetch front end directly upstream of the pipelined datapath's IF/ID register.
- Generates the sequential PC.
- Issues requests to a variable-latency instruction memory over a ready/valid handshake.
- Queues returned words in a small FIFO.
- Presents instruction, PC and PC+4 to decode.
- On taken branch/jump (PCSrcE), redirects fetch and discards queued and in-flight stale words.

Parameters:
DEPTH, 4, FIFO entries; power of two, >= 2.
MAX_OUTSTANDING, 2, max imem requests in flight, including ones being dropped; >= 1.
RESET_PC, 32'h0000_0000, first fetch address after reset.

Ports:
clk  in  1  clock, rising edge.
rst  in  1  synchronous reset, active high.
PCSrcE  in  1  redirect from EX stage.
PCTargetE  in  32  redirect target.
StallD  in  1  decode holds; no pop.
imem_req_valid  out  1  request valid.
imem_req_addr  out  32  word-aligned fetch address.
imem_req_ready  in  1  memory accepts request this cycle.
imem_rsp_valid  in  1  response word valid; responses return in request order.
imem_rsp_data  in  32  instruction word.
InstrF  out  32  head instruction; NOP (32'h0000_0013) when empty.
PCF  out  32  PC of head entry; 0 when empty.
PCPlus4F  out  32  PCF+4; 0 when empty.
instr_valid  out  1  head entry valid.

Behaviour:
- Reset (rst high at clk edge):
  - fetch_pc = RESET_PC; FIFO empty; outstanding = 0; drop_cnt = 0.
  - instr_valid = 0, InstrF = NOP, PCF = PCPlus4F = 0.
  - imem_req_valid = 0 while rst is high. Reset mid-transfer abandons everything; responses arriving after reset are counted against nothing and ignored until the first post-reset request is issued.
- Issue:
  - Condition: imem_req_valid = !rst && (fifo_count_eff + live_outstanding < DEPTH) && (outstanding < MAX_OUTSTANDING).
  - fifo_count_eff = 0 and live_outstanding = 0 in a PCSrcE cycle; otherwise fifo_count and outstanding - drop_cnt.
  - imem_req_addr = PCSrcE ? PCTargetE : fetch_pc.
  - Handshake completes on imem_req_valid && imem_req_ready.
  - Next fetch_pc: (issued address)+4 if accepted; else PCTargetE on redirect, otherwise unchanged.
  - Address is not required to be stable while ready is low; a redirect may change it.
- Outstanding counter: +1 on accept, -1 on imem_rsp_valid, both in one cycle = no change. It never exceeds MAX_OUTSTANDING.
- Response:
  - If drop_cnt > 0 or PCSrcE is high that cycle: discard the word and decrement drop_cnt if it is nonzero.
  - Otherwise push {pc, instr}. Push pc comes from a pc-tag queue of issued addresses, or equivalently a rsp_pc register advanced +4 per pushed word and reloaded on redirect.
- Redirect (PCSrcE high):
  - FIFO cleared at the edge.
  - drop_cnt <= outstanding - (imem_rsp_valid ? 1 : 0); the request issued in the same cycle is not dropped.
  - Pop suppressed; redirect wins over StallD.
- Pop: instr_valid && !StallD && !PCSrcE advances the head. Push and pop in the same cycle are allowed, including when full; the credit check guarantees no overflow.
- Outputs: registered from FIFO head; no combinational path from imem_rsp to outputs.
  - Minimum latency: request accepted cycle N, response cycle N+k, instr_valid at N+k+1.
- Wrap-around: fetch_pc rolls over mod 2^32 with no special handling.

Optional Feature:
FETCH_BYPASS_EN
- Defined: when the FIFO is empty (or being popped to empty) and a non-dropped response arrives, InstrF/PCF/PCPlus4F/instr_valid show it combinationally in the same cycle. The word is pushed only if not popped that cycle. Latency drops by 1.
- Undefined: all outputs come from the registered FIFO head, as specified above.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR = 32'h0000_0013, RESET_PC_DEFAULT.
  - fetch_entry_t {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with DEPTH, push/pop/flush, count, full, empty.
- Top module holds the PC, outstanding and drop counters, and the issue logic.

Test Plan:
- Reset then imem_req_ready = 1, 1-cycle response latency → requests at 0x0, 0x4, 0x8…; instr_valid first high 2 cycles after rst falls with PCF = 0x0; with StallD = 0, one instruction per cycle.
- StallD held high for 10 cycles → exactly DEPTH (4) words queued, imem_req_valid then low; releasing StallD pops 0x0..0xC in order with no loss.
- 2 requests outstanding (latency 3), PCSrcE = 1 with PCTargetE = 0x100 → FIFO empty next cycle, both stale responses dropped, next instr_valid has PCF = 0x100 and PCPlus4F = 0x104.
- PCSrcE, imem_rsp_valid and StallD all high in one cycle → response discarded, drop_cnt = outstanding - 1, no pop, redirect takes effect.
- imem_req_ready low for 5 cycles with a redirect during the wait → imem_req_addr switches to the target, which is accepted when ready rises; no duplicate or skipped PC.
- FETCH_BYPASS_EN defined, FIFO empty, response for 0x40 arrives → instr_valid and PCF = 0x40 in the same cycle; with StallD = 0 the FIFO stays empty.
